// File: rtl/wb_pwm_multi.sv
// Multi-channel PWM generator behind a Wishbone B4 pipelined slave.
// Supports edge/center alignment, prescaling, per-channel polarity and double-buffered period/duty.
module wb_pwm_multi #(
  parameter int WB_ADDR_BITS = 32,
  parameter int PWM_BITS     = 8,
  parameter int PWM_PINS     = 4,
  parameter int PRESC_BITS   = 8
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst_n,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [WB_ADDR_BITS-1:0] i_wb_addr,
  input  logic [31:0]             i_wb_data,
  output logic [31:0]             o_wb_data,
  output logic                    o_wb_stall,
  output logic                    o_wb_ack,
  output logic [PWM_PINS-1:0]     o_pwm_channel,
  output logic                    o_pwm_period
);

  localparam logic [WB_ADDR_BITS-1:0] A_CTRL   = WB_ADDR_BITS'(0);
  localparam logic [WB_ADDR_BITS-1:0] A_PERIOD = WB_ADDR_BITS'(1);
  localparam logic [WB_ADDR_BITS-1:0] A_PRESC  = WB_ADDR_BITS'(2);
  localparam logic [WB_ADDR_BITS-1:0] A_POL    = WB_ADDR_BITS'(3);
  localparam logic [WB_ADDR_BITS-1:0] A_STATUS = WB_ADDR_BITS'(4);
  localparam logic [WB_ADDR_BITS-1:0] A_DUTY   = WB_ADDR_BITS'(8);

  logic                  r_en, r_mode;
  logic [PWM_BITS-1:0]   r_period_pend, r_period_act;
  logic [PRESC_BITS-1:0] r_presc, r_presc_cnt;
  logic [PWM_PINS-1:0]   r_pol, r_pwm;
  logic [PWM_BITS-1:0]   r_duty_pend [PWM_PINS];
  logic [PWM_BITS-1:0]   r_duty_act  [PWM_PINS];
  logic [PWM_BITS-1:0]   r_cnt;
  logic                  r_dir;
  logic                  r_ack, r_pulse;
  logic [31:0]           r_rdata;

  logic        w_wr, w_tick, w_boundary, w_restart;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_wr      = i_wb_stb & i_wb_we;
  assign w_tick    = r_en && (r_presc_cnt >= r_presc);
  assign w_restart = w_wr && (i_wb_addr == A_CTRL) && (i_wb_data[1] != r_mode);
  // Center mode with PERIOD=0 never leaves 0, so every tick closes a period.
  assign w_boundary = r_mode ? (w_tick && ((r_cnt == '0 && r_dir) || r_period_act == '0))
                             : (w_tick && (r_cnt >= r_period_act));
  assign w_unused  = ^i_wb_data;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_en          <= 1'b0;
      r_mode        <= 1'b0;
      r_period_pend <= '0;
      r_presc       <= '0;
      r_pol         <= '0;
      for (int n = 0; n < PWM_PINS; n++) r_duty_pend[n] <= '0;
    end else if (w_wr) begin
      case (i_wb_addr)
        A_CTRL:   {r_mode, r_en} <= i_wb_data[1:0];
        A_PERIOD: r_period_pend  <= i_wb_data[PWM_BITS-1:0];
        A_PRESC:  r_presc        <= i_wb_data[PRESC_BITS-1:0];
        A_POL:    r_pol          <= i_wb_data[PWM_PINS-1:0];
        default:  ;
      endcase
      for (int n = 0; n < PWM_PINS; n++)
        if (i_wb_addr == A_DUTY + WB_ADDR_BITS'(n)) r_duty_pend[n] <= i_wb_data[PWM_BITS-1:0];
    end
  end

  // Pending values reach the comparators only at a period boundary, or freely while stopped.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_period_act <= '0;
      for (int n = 0; n < PWM_PINS; n++) r_duty_act[n] <= '0;
    end else if (!r_en || w_boundary) begin
      r_period_act <= r_period_pend;
      for (int n = 0; n < PWM_PINS; n++) r_duty_act[n] <= r_duty_pend[n];
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_presc_cnt <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
    end else if (!r_en || w_restart) begin
      r_presc_cnt <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
    end else begin
      r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
      if (w_tick) begin
        if (!r_mode) begin
          r_dir <= 1'b0;
          r_cnt <= (r_cnt >= r_period_act) ? '0 : r_cnt + 1'b1;
        end else if (!r_dir) begin
          if (r_cnt >= r_period_act) begin
            if (r_period_act != '0) begin
              r_cnt <= r_period_act - 1'b1;
              r_dir <= 1'b1;
            end else begin
              r_cnt <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else if (r_cnt == '0) begin
          // Turning point at zero: next period starts with the period just loaded.
          r_dir <= 1'b0;
          r_cnt <= (r_period_pend != '0) ? PWM_BITS'(1) : '0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (i_wb_addr)
      A_CTRL:   w_rdata[1:0] = {r_mode, r_en};
      A_PERIOD: w_rdata[PWM_BITS-1:0] = r_period_pend;
      A_PRESC:  w_rdata[PRESC_BITS-1:0] = r_presc;
      A_POL:    w_rdata[PWM_PINS-1:0] = r_pol;
      A_STATUS: begin
        w_rdata[PWM_BITS-1:0] = r_cnt;
        w_rdata[16]           = r_dir;
      end
      default:  ;
    endcase
    for (int n = 0; n < PWM_PINS; n++)
      if (i_wb_addr == A_DUTY + WB_ADDR_BITS'(n)) w_rdata[PWM_BITS-1:0] = r_duty_pend[n];
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_pulse <= 1'b0;
      r_pwm   <= '0;
    end else begin
      r_ack   <= i_wb_stb;
      r_rdata <= i_wb_stb ? w_rdata : '0;
      r_pulse <= w_boundary;
      for (int n = 0; n < PWM_PINS; n++)
        r_pwm[n] <= r_en ? ((r_cnt < r_duty_act[n]) ^ r_pol[n]) : r_pol[n];
    end
  end

  assign o_wb_ack      = r_ack;
  assign o_wb_data     = r_rdata;
  assign o_wb_stall    = 1'b0;
  assign o_pwm_channel = r_pwm;
  assign o_pwm_period  = r_pulse;

endmodule

// File: tb/tb_wb_pwm_multi.sv
// Self-checking bench for wb_pwm_multi: table-driven register accesses with a read-data
// scoreboard, plus waveform captures aligned on the period pulse.
module tb_wb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, we;
  logic [31:0] addr, wdata;
  logic [31:0] o_wb_data;
  logic        o_wb_stall, o_wb_ack, o_pwm_period;
  logic [3:0]  o_pwm_channel;

  int n_tests = 0;
  int n_fail  = 0;
  logic        stb_d;
  logic        stall_bad = 1'b0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[19];

  wb_pwm_multi dut (
    .i_wb_clk      (clk),
    .i_wb_rst_n    (rst_n),
    .i_wb_stb      (stb),
    .i_wb_we       (we),
    .i_wb_addr     (addr),
    .i_wb_data     (wdata),
    .o_wb_data     (o_wb_data),
    .o_wb_stall    (o_wb_stall),
    .o_wb_ack      (o_wb_ack),
    .o_pwm_channel (o_pwm_channel),
    .o_pwm_period  (o_pwm_period)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) stb_d <= 1'b0;
    else        stb_d <= stb;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: ack must follow every strobe by one cycle; read data popped in order.
  always @(negedge clk) begin
    logic [32:0] e;
    if (o_wb_stall !== 1'b0) stall_bad = 1'b1;
    if (stb_d || o_wb_ack) chk("ack_timing", o_wb_ack, stb_d);
    if (o_wb_ack === 1'b1) begin
      if (exp_q.size() == 0) chk("ack_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        if (e[32]) chk("rdata", o_wb_data, e[31:0]);
      end
    end else if (rst_n) begin
      chk("rdata_idle", o_wb_data, 0);
    end
  end

  task automatic beat(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] e);
    @(posedge clk); #1;
    stb = 1'b1; we = w; addr = a; wdata = d;
    exp_q.push_back({~w, e});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_pulse(input int max, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = o_pwm_period;
    end
    chk(name, seen, 1);
  endtask

  // Sample k=0 now (at a negedge), then one sample per following negedge.
  task automatic capture(input int n, output logic [63:0] p0, output logic [63:0] p1,
                         output logic [63:0] p2, output logic [63:0] p3, output logic [63:0] pp);
    p0 = '0; p1 = '0; p2 = '0; p3 = '0; pp = '0;
    for (int k = 0; k < n; k++) begin
      if (k != 0) @(negedge clk);
      p0[k] = o_pwm_channel[0];
      p1[k] = o_pwm_channel[1];
      p2[k] = o_pwm_channel[2];
      p3[k] = o_pwm_channel[3];
      pp[k] = o_pwm_period;
    end
  endtask

  logic [63:0] c0, c1, c2, c3, cp;

  initial begin
    tbl[0]  = '{1'b1, 32'd1,     32'hFFFF_FF09, 32'd0};
    tbl[1]  = '{1'b1, 32'd2,     32'h0000_0100, 32'd0};
    tbl[2]  = '{1'b1, 32'd8,     32'd3,         32'd0};
    tbl[3]  = '{1'b1, 32'd9,     32'd0,         32'd0};
    tbl[4]  = '{1'b1, 32'd10,    32'hABCD_000A, 32'd0};
    tbl[5]  = '{1'b1, 32'd11,    32'd5,         32'd0};
    tbl[6]  = '{1'b0, 32'd1,     32'd0,         32'd9};
    tbl[7]  = '{1'b0, 32'd2,     32'd0,         32'd0};
    tbl[8]  = '{1'b0, 32'd10,    32'd0,         32'd10};
    tbl[9]  = '{1'b0, 32'd8,     32'd0,         32'd3};
    tbl[10] = '{1'b1, 32'd5,     32'hFFFF_FFFF, 32'd0};
    tbl[11] = '{1'b1, 32'h100,   32'hFF,        32'd0};
    tbl[12] = '{1'b0, 32'd5,     32'd0,         32'd0};
    tbl[13] = '{1'b0, 32'h100,   32'd0,         32'd0};
    tbl[14] = '{1'b0, 32'd4,     32'd0,         32'd0};
    tbl[15] = '{1'b0, 32'd0,     32'd0,         32'd0};
    tbl[16] = '{1'b0, 32'd1,     32'd0,         32'd9};
    tbl[17] = '{1'b1, 32'd3,     32'hF0,        32'd0};
    tbl[18] = '{1'b0, 32'd3,     32'd0,         32'd0};

    rst_n = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", o_pwm_channel, 0);
    chk("rst_period", o_pwm_period, 0);
    chk("rst_ack", o_wb_ack, 0);
    chk("rst_data", o_wb_data, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) beat(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp);
    idle();
    drain();
    chk("idle_out", o_pwm_channel, 4'b0000);

    // Edge mode: PERIOD 9, duties 3/0/10/5.
    beat(1'b1, 32'd0, 32'd1, 32'd0);
    idle();
    wait_pulse(30, "edge_first_pulse");
    capture(10, c0, c1, c2, c3, cp);
    chk("edge_ch0", c0, 64'h00E);
    chk("edge_ch1", c1, 64'h000);
    chk("edge_ch2", c2, 64'h3FF);
    chk("edge_ch3", c3, 64'h03E);
    chk("edge_pulse", cp, 64'h001);

    // Mid-period duty write: takes effect one period later.
    wait_pulse(12, "db_pulse");
    fork
      capture(20, c0, c1, c2, c3, cp);
      begin beat(1'b1, 32'd8, 32'd7, 32'd0); idle(); end
    join
    chk("db_mid_ch0", c0, 64'h3F80E);
    chk("db_mid_pulse", cp, 64'h00401);

    // Write landing in the boundary cycle: deferred by a further period.
    wait_pulse(12, "db_bnd_pulse");
    fork
      capture(30, c0, c1, c2, c3, cp);
      begin repeat (8) @(posedge clk); beat(1'b1, 32'd8, 32'd2, 32'd0); idle(); end
    join
    chk("db_bnd_ch0", c0, 64'h63F8FE);
    chk("db_bnd_pulse", cp, 64'h100401);
    drain();

    // Polarity then disable: outputs follow POL, counter parked.
    beat(1'b1, 32'd3, 32'd1, 32'd0);
    beat(1'b1, 32'd0, 32'd0, 32'd0);
    idle();
    @(negedge clk); @(negedge clk);
    chk("dis_out", o_pwm_channel, 4'b0001);
    chk("dis_pulse", o_pwm_period, 0);
    beat(1'b0, 32'd4, 32'd0, 32'd0);
    idle();
    drain();

    // PERIOD written while disabled is live as soon as EN rises.
    beat(1'b1, 32'd1, 32'd3, 32'd0);
    beat(1'b1, 32'd0, 32'd1, 32'd0);
    idle();
    wait_pulse(8, "p3_first_pulse");
    capture(8, c0, c1, c2, c3, cp);
    chk("p3_ch0_inv", c0, 64'h99);
    chk("p3_ch1", c1, 64'h00);
    chk("p3_ch2", c2, 64'hFF);
    chk("p3_ch3", c3, 64'hFF);
    chk("p3_pulse", cp, 64'h11);
    drain();

    // Center mode with prescaler 1, PERIOD 4, DUTY0 2.
    beat(1'b1, 32'd0, 32'd0, 32'd0);
    beat(1'b1, 32'd3, 32'd0, 32'd0);
    beat(1'b1, 32'd2, 32'd1, 32'd0);
    beat(1'b1, 32'd1, 32'd4, 32'd0);
    beat(1'b1, 32'd0, 32'd3, 32'd0);
    idle();
    wait_pulse(60, "ctr_first_pulse");
    capture(32, c0, c1, c2, c3, cp);
    chk("ctr_ch0", c0, 64'hE007E007);
    chk("ctr_ch2", c2, 64'hFFFFFFFF);
    chk("ctr_pulse", cp, 64'h00010001);
    wait_pulse(4, "ctr_next_pulse");
    beat(1'b0, 32'd4, 32'd0, 32'h0000_0001);
    idle();
    repeat (7) @(posedge clk);
    beat(1'b0, 32'd4, 32'd0, 32'h0001_0002);
    idle();
    drain();

    // Asynchronous reset mid-period.
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pwm", o_pwm_channel, 0);
    chk("mid_rst_period", o_pwm_period, 0);
    chk("mid_rst_ack", o_wb_ack, 0);
    chk("mid_rst_data", o_wb_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 32'd0, 32'd0, 32'd0);
    beat(1'b0, 32'd1, 32'd0, 32'd0);
    beat(1'b0, 32'd10, 32'd0, 32'd0);
    idle();
    drain();
    repeat (20) @(negedge clk);
    chk("post_rst_pwm", o_pwm_channel, 0);
    chk("stall_zero", stall_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
